// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - measures period and high time of a sampled clock and flags bad or stuck waveforms
module clk_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 100,
    parameter int EXP_HIGH   = 50,
    parameter int TOL        = 2,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mon_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             period_ok,
    output logic             duty_ok,
    output logic             stuck
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    EXP_PER_X = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]    EXP_HI_X  = (CNT_W+1)'(EXP_HIGH);
    localparam logic [CNT_W:0]    TOL_X     = (CNT_W+1)'(TOL);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    state_t state_q, state_d;
    logic sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]  per_q, per_d, hi_q, hi_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              pend_q, pend_d;
    logic              meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
    logic              period_ok_q, period_ok_d, duty_ok_q, duty_ok_d;
    logic              stuck_q, stuck_d;

    logic rise, fall, timeout;
    logic [CNT_W-1:0] per_inc, hi_inc;
    logic [CNT_W:0]   per_x, hi_x, per_diff, hi_diff;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= mon_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    always_comb begin
        per_inc  = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;
        hi_inc   = (hi_q == CNT_MAX) ? hi_q : hi_q + 1'b1;
        per_x    = {1'b0, period_cnt_q};
        hi_x     = {1'b0, high_cnt_q};
        per_diff = (per_x >= EXP_PER_X) ? per_x - EXP_PER_X : EXP_PER_X - per_x;
        hi_diff  = (hi_x >= EXP_HI_X) ? hi_x - EXP_HI_X : EXP_HI_X - hi_x;
    end

    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        hi_d         = hi_q;
        idle_d       = idle_q;
        pend_d       = 1'b0;
        meas_valid_d = 1'b0;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_ok_d  = period_ok_q;
        duty_ok_d    = duty_ok_q;
        stuck_d      = stuck_q;
        timeout      = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            per_d   = '0;
            hi_d    = '0;
            idle_d  = '0;
            stuck_d = 1'b0;
        end else begin
            // Flags are judged one cycle after capture, so they change together with meas_valid.
            if (pend_q) begin
                meas_valid_d = 1'b1;
                period_ok_d  = (period_cnt_q != CNT_MAX) && (per_diff <= TOL_X);
                duty_ok_d    = (high_cnt_q != CNT_MAX) && (hi_diff <= TOL_X);
            end

            if (rise || fall) begin
                idle_d  = '0;
                stuck_d = 1'b0;
            end else if (state_q != S_IDLE) begin
                if (idle_q == IDLE_LAST) begin
                    timeout = 1'b1;
                    idle_d  = '0;
                    stuck_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    per_d   = '0;
                    hi_d    = '0;
                    idle_d  = '0;
                    state_d = S_ARM;
                end
                S_ARM: begin
                    if (rise) begin
                        per_d   = CNT_W'(1);
                        hi_d    = CNT_W'(1);
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (timeout) begin
                        per_d   = '0;
                        hi_d    = '0;
                        state_d = S_ARM;
                    end else begin
                        per_d = per_inc;
                        if (fall) begin
                            state_d = S_LOW;
                        end else begin
                            hi_d = hi_inc;
                        end
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        period_cnt_d = per_q;
                        high_cnt_d   = hi_q;
                        pend_d       = 1'b1;
                        per_d        = CNT_W'(1);
                        hi_d         = CNT_W'(1);
                        state_d      = S_HIGH;
                    end else if (timeout) begin
                        per_d   = '0;
                        hi_d    = '0;
                        state_d = S_ARM;
                    end else begin
                        per_d = per_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            per_q        <= '0;
            hi_q         <= '0;
            idle_q       <= '0;
            pend_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_ok_q  <= 1'b0;
            duty_ok_q    <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_q        <= per_d;
            hi_q         <= hi_d;
            idle_q       <= idle_d;
            pend_q       <= pend_d;
            meas_valid_q <= meas_valid_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_ok_q  <= period_ok_d;
            duty_ok_q    <= duty_ok_d;
            stuck_q      <= stuck_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period_cnt = period_cnt_q;
    assign high_cnt   = high_cnt_q;
    assign period_ok  = period_ok_q;
    assign duty_ok    = duty_ok_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - directed self-checking bench for clk_monitor
module tb_clk_monitor;

    localparam int LAT     = 3;
    localparam int TIMEOUT = 1000;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        mon_in  = 1'b0;
    logic        meas_valid;
    logic [15:0] period_cnt;
    logic [15:0] high_cnt;
    logic        period_ok;
    logic        duty_ok;
    logic        stuck;

    always #5 clock = ~clock;

    clk_monitor #(
        .CNT_W(16), .EXP_PERIOD(100), .EXP_HIGH(50), .TOL(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mon_in(mon_in),
        .meas_valid(meas_valid), .period_cnt(period_cnt), .high_cnt(high_cnt),
        .period_ok(period_ok), .duty_ok(duty_ok), .stuck(stuck)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ph;
    int npulse, first_ph, prev_ph, last_ph;
    int cap_per, cap_hi, cap_pok, cap_dok;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_window();
        npulse   = 0;
        first_ph = -1;
        prev_ph  = -1;
        last_ph  = -1;
    endtask

    // Sample at each negedge, then drive the waveform value for phase ph.
    task automatic run_wave(input int p, input int h, input int until_ph);
        while (ph < until_ph) begin
            @(negedge clock);
            if (meas_valid) begin
                npulse++;
                if (first_ph < 0) first_ph = ph;
                prev_ph = last_ph;
                last_ph = ph;
                cap_per = int'(period_cnt);
                cap_hi  = int'(high_cnt);
                cap_pok = int'(period_ok);
                cap_dok = int'(duty_ok);
            end
            mon_in = ((ph % p) < h);
            ph++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        mon_in  = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        ph = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(meas_valid), 0);
        check({tag, "_period"}, int'(period_cnt), 0);
        check({tag, "_high"}, int'(high_cnt), 0);
        check({tag, "_pok"}, int'(period_ok), 0);
        check({tag, "_dok"}, int'(duty_ok), 0);
        check({tag, "_stuck"}, int'(stuck), 0);
    endtask

    task automatic test_wave(input string tag, input int p, input int h,
                             input int exp_pok, input int exp_dok);
        do_reset();
        enable = 1'b1;
        clear_window();
        run_wave(p, h, 5 * p + 20);
        check({tag, "_pulses"}, npulse, 5);
        check({tag, "_first"}, first_ph, p + LAT + 1);
        check({tag, "_spacing"}, last_ph - prev_ph, p);
        check({tag, "_period"}, cap_per, p);
        check({tag, "_high"}, cap_hi, h);
        check({tag, "_pok"}, cap_pok, exp_pok);
        check({tag, "_dok"}, cap_dok, exp_dok);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_stk;
        int hold_pulses;

        do_reset();
        check_zero("reset");

        test_wave("p100h50", 100, 50, 1, 1);
        test_wave("p100h30", 100, 30, 1, 0);
        test_wave("p50h25", 50, 25, 0, 0);
        test_wave("p102h52", 102, 52, 1, 1);
        test_wave("p98h48", 98, 48, 1, 1);
        test_wave("p97h53", 97, 53, 0, 0);

        // stuck low after a valid period
        do_reset();
        enable = 1'b1;
        clear_window();
        run_wave(100, 50, 150);
        check("stk_pre_pulses", npulse, 1);
        first_stk   = -1;
        hold_pulses = 0;
        for (int j = 0; j < 1200; j++) begin
            @(negedge clock);
            if (j > 0 && stuck && first_stk < 0) first_stk = j;
            if (meas_valid) hold_pulses++;
            mon_in = 1'b0;
        end
        check("stk_time", first_stk, LAT + TIMEOUT);
        check("stk_no_pulse", hold_pulses, 0);
        check("stk_sticky", int'(stuck), 1);
        check("stk_hold_period", int'(period_cnt), 100);
        ph = 0;
        clear_window();
        run_wave(100, 50, 6);
        check("stk_cleared", int'(stuck), 0);
        run_wave(100, 50, 120);
        check("stk_after_pulses", npulse, 1);
        check("stk_after_first", first_ph, 100 + LAT + 1);
        check("stk_after_period", cap_per, 100);

        // enable dropped mid-HIGH
        do_reset();
        enable = 1'b1;
        clear_window();
        run_wave(100, 50, 125);
        check("en_pre_pulses", npulse, 1);
        enable = 1'b0;
        clear_window();
        run_wave(100, 50, 145);
        check("en_off_pulses", npulse, 0);
        check("en_hold_period", int'(period_cnt), 100);
        check("en_hold_high", int'(high_cnt), 50);
        check("en_hold_pok", int'(period_ok), 1);
        check("en_hold_dok", int'(duty_ok), 1);
        enable = 1'b1;
        clear_window();
        run_wave(100, 50, 320);
        check("en_on_pulses", npulse, 1);
        check("en_on_first", first_ph, 300 + LAT + 1);
        check("en_on_period", cap_per, 100);
        check("en_on_high", cap_hi, 50);

        // reset pulse mid-LOW
        do_reset();
        enable = 1'b1;
        clear_window();
        run_wave(100, 50, 170);
        reset_n = 1'b0;
        @(negedge clock);
        ph++;
        reset_n = 1'b1;
        check_zero("rst_mid");
        clear_window();
        run_wave(100, 50, 420);
        check("rst_pulses", npulse, 2);
        check("rst_first", first_ph, 300 + LAT + 1);
        check("rst_spacing", last_ph - prev_ph, 100);
        check("rst_period", cap_per, 100);
        check("rst_high", cap_hi, 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
